// File: rtl/axi_read_responder_if.sv
// AXI4-Lite read-channel bundle (AR + R) between a core and a read-only responder.
//
// Signals:
//   arvalid   core -> responder  read address valid
//   arready   responder -> core  responder accepts the address
//   araddress core -> responder  32-bit byte address
//   arprot    core -> responder  protection bits (carried, not interpreted)
//   rvalid    responder -> core  read data valid
//   rready    core -> responder  core accepts read data
//   rdata     responder -> core  32-bit read data
//   rresp     responder -> core  2'b00 OKAY, 2'b10 SLVERR
//
// Modports: master (core side), slave (responder side).
interface axi_read_responder_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddress;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output arvalid, araddress, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddress, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_read_responder.sv
// AXI4-Lite read-only slave backed by a preloadable word memory.
// One outstanding read: an address is taken in IDLE, the response appears
// LATENCY cycles later and is held until the core takes it.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 2)
//   BASE    byte address of word 0 (DEPTH*4 aligned)
//   LATENCY cycles from AR handshake to rvalid (1..15)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-low
//   bus         axi_read_responder_if.slave (AR/R channels)
//   load_en     preload strobe, honoured only while idle
//   load_index  preload word index
//   load_data   preload word
//
// Optional feature: define AXI_READ_RESPONDER_ALIGN_CHECK_EN to answer
// in-range addresses with araddress[1:0] != 0 with SLVERR instead of the
// aligned word.
module axi_read_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  axi_read_responder_if.slave      bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_index,
  input  logic [31:0]              load_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  // One past the last byte served; 33 bits so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) * 33'd4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            ar_hs;
  logic [31:0]     addr_off;
  logic [AW-1:0]   word_idx;
  logic            misaligned;
  logic [31:0]     rd_word;
  logic [1:0]      rd_resp;
  logic            unused_bits;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < LIMIT);
  endfunction

  // arready is gated by reset so it reads 0 during reset and rises the
  // first cycle after release; it never looks at arvalid.
  assign bus.arready = (state == IDLE) && reset;
  assign bus.rvalid  = (state == RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign ar_hs = bus.arvalid && bus.arready;

  // Word lookup for the address presented this cycle.
  assign addr_off = bus.araddress - BASE;
  assign word_idx = addr_off[AW+1:2];

`ifdef AXI_READ_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = |bus.araddress[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    rd_word = 32'h0;
    rd_resp = 2'b10;
    if (addr_in_range(bus.araddress) && !misaligned) begin
      rd_word = mem[word_idx];
      rd_resp = 2'b00;
    end
  end

  // Byte-offset bits and protection bits carry no meaning here.
  assign unused_bits = ^{bus.arprot, addr_off[1:0], addr_off[31:AW+2]};

  // FSM next state; the counter is loaded with LATENCY-1 at the handshake
  // and the last WAIT cycle is the one where it reads 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY == 1) state_next = RESP;
          else              state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        if (bus.rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Response is captured at the handshake, so a later preload cannot change it
  // and a same-cycle preload returns the old word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= 32'h0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= rd_word;
      rresp_q <= rd_resp;
    end
  end

  // Memory has no reset so its contents survive one.
  always_ff @(posedge clk) begin
    if (load_en && (state == IDLE)) mem[load_index] <= load_data;
  end
endmodule

// File: tb/tb_axi_read_responder.sv
module tb_axi_read_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddress = 32'h0;
  logic [2:0]  arprot = 3'h0;
  logic        rready = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_index = 8'h0;
  logic [31:0] load_data = 32'h0;

  always #5 clk = ~clk;

  axi_read_responder_if ifa ();
  axi_read_responder_if ifb ();

  assign ifa.arvalid = arvalid;  assign ifb.arvalid = arvalid;
  assign ifa.araddress = araddress;  assign ifb.araddress = araddress;
  assign ifa.arprot = arprot;  assign ifb.arprot = arprot;
  assign ifa.rready = rready;  assign ifb.rready = rready;

  // A: 256 words at 0, one-cycle latency.  B: 16 words at 0x1040, latency 3.
  axi_read_responder #(.DEPTH(256), .BASE(32'h0000_0000), .LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .load_en(load_en), .load_index(load_index), .load_data(load_data));

  axi_read_responder #(.DEPTH(16), .BASE(32'h0000_1040), .LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .load_en(load_en), .load_index(load_index[3:0]), .load_data(load_data));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending read is described by the cycle its response
  // becomes due; memory is a plain array per DUT.
  bit          mon_en = 1'b0;
  longint      cyc = 0;
  bit          pend [2];
  longint      due [2];
  logic [31:0] edata [2];
  logic [1:0]  eresp [2];
  logic [31:0] mdl [2][256];

  task automatic model_step(input int d, input int lat, input longint base, input int depth,
                            input logic ardy, input logic rv,
                            input logic [31:0] rd, input logic [1:0] rr);
    string  tag;
    bit     x_ardy, x_rv, mis;
    longint a;
    tag    = (d == 0) ? "A" : "B";
    x_ardy = !pend[d] && reset;
    x_rv   = pend[d] && (cyc >= due[d]);
    check({tag, " arready"}, 32'(ardy), 32'(x_ardy));
    check({tag, " rvalid"}, 32'(rv), 32'(x_rv));
    if (x_rv) begin
      check({tag, " rdata"}, rd, edata[d]);
      check({tag, " rresp"}, 32'(rr), 32'(eresp[d]));
    end
    if (!reset) begin
      pend[d] = 1'b0;
    end else if (!pend[d]) begin
      if (arvalid) begin
        a   = {32'h0, araddress};
        mis = 1'b0;
`ifdef AXI_READ_RESPONDER_ALIGN_CHECK_EN
        mis = (araddress[1:0] != 2'b00);
`endif
        pend[d] = 1'b1;
        due[d]  = cyc + lat;
        if (a >= base && a < base + longint'(depth) * 4 && !mis) begin
          edata[d] = mdl[d][int'((a - base) >> 2) % depth];
          eresp[d] = 2'b00;
        end else begin
          edata[d] = 32'h0;
          eresp[d] = 2'b10;
        end
      end
      if (load_en) mdl[d][int'(load_index) % depth] = load_data;
    end else if (x_rv && rready) begin
      pend[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      model_step(0, 1, 64'h0, 256, ifa.arready, ifa.rvalid, ifa.rdata, ifa.rresp);
      model_step(1, 3, 64'h1040, 16, ifb.arready, ifb.rvalid, ifb.rdata, ifb.rresp);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed read on both DUTs with hand-computed results; the core holds
  // rready low for 'hold' cycles after the handshake.
  task automatic rd(input string tag, input logic [31:0] a, input int hold,
                    input logic [31:0] xa_d, input logic [1:0] xa_r,
                    input logic [31:0] xb_d, input logic [1:0] xb_r,
                    input bit ld, input logic [31:0] ld_data);
    int fa, fb;
    bit da, db;
    logic [31:0] va, vb;
    logic [1:0] ra, rb;
    fa = -1; fb = -1; da = 0; db = 0;
    va = 32'h0; vb = 32'h0; ra = 2'b00; rb = 2'b00;
    arvalid = 1'b1; araddress = a; rready = 1'b0;
    load_en = ld; load_index = 8'd2; load_data = ld_data;
    @(negedge clk);
    check({tag, " A arready at AR"}, 32'(ifa.arready), 32'd1);
    check({tag, " B arready at AR"}, 32'(ifb.arready), 32'd1);
    tick();
    arvalid = 1'b0; load_en = 1'b0;
    for (int k = 1; k <= 40 && !(da && db); k++) begin
      rready = (k > hold);
      @(negedge clk);
      if (!da && ifa.rvalid) begin
        if (fa < 0) begin fa = k; va = ifa.rdata; ra = ifa.rresp; end
        else check({tag, " A held data"}, ifa.rdata ^ 32'(ifa.rresp), va ^ 32'(ra));
        da = rready;
      end
      if (!db) check({tag, " B arready busy"}, 32'(ifb.arready), 32'd0);
      if (!db && ifb.rvalid) begin
        if (fb < 0) begin fb = k; vb = ifb.rdata; rb = ifb.rresp; end
        else check({tag, " B held data"}, ifb.rdata ^ 32'(ifb.rresp), vb ^ 32'(rb));
        db = rready;
      end
      tick();
    end
    rready = 1'b0;
    check({tag, " A done"}, 32'(da), 32'd1);
    check({tag, " B done"}, 32'(db), 32'd1);
    check({tag, " A latency"}, 32'(fa), 32'd1);
    check({tag, " B latency"}, 32'(fb), 32'd3);
    check({tag, " A rdata"}, va, xa_d);
    check({tag, " A rresp"}, 32'(ra), 32'(xa_r));
    check({tag, " B rdata"}, vb, xb_d);
    check({tag, " B rresp"}, 32'(rb), 32'(xb_r));
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = $urandom_range(0, 32'h4FF);
      1: r = 32'h1040 + $urandom_range(0, 63);
      2: begin
        case ($urandom_range(0, 7))
          0: r = 32'h3FC;  1: r = 32'h400;  2: r = 32'h1040;  3: r = 32'h107C;
          4: r = 32'h1080; 5: r = 32'h103C; 6: r = 32'h0;     default: r = 32'hFFFF_FFFC;
        endcase
      end
      3: r = $urandom;
      default: r = $urandom_range(0, 32'h3FF) & 32'hFFFF_FFFC;
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] xa6_d;
    logic [1:0]  xa6_r;
    // Reset state.
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset A arready", 32'(ifa.arready), 32'd0);
    check("reset A rvalid", 32'(ifa.rvalid), 32'd0);
    check("reset A rdata", ifa.rdata, 32'h0);
    check("reset A rresp", 32'(ifa.rresp), 32'd0);
    check("reset B arready", 32'(ifb.arready), 32'd0);
    check("reset B rvalid", 32'(ifb.rvalid), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("release A arready", 32'(ifa.arready), 32'd1);
    check("release B arready", 32'(ifb.arready), 32'd1);
    tick();

    // Preload: word i = C0_ii_0F0F, word 0 = 0x13.  B keeps i = 240..255.
    for (int i = 0; i < 256; i++) begin
      load_en = 1'b1;
      load_index = 8'(i);
      load_data = (i == 0) ? 32'h0000_0013 : {8'hC0, 8'(i), 16'h0F0F};
      tick();
    end
    load_en = 1'b0;

    rd("word0", 32'h0, 0, 32'h0000_0013, 2'b00, 32'h0, 2'b10, 0, 32'h0);
    rd("stall", 32'h1044, 5, 32'h0, 2'b10, 32'hC0F1_0F0F, 2'b00, 0, 32'h0);
    rd("A top", 32'h3FC, 1, 32'hC0FF_0F0F, 2'b00, 32'h0, 2'b10, 0, 32'h0);
    rd("A past", 32'h400, 0, 32'h0, 2'b10, 32'h0, 2'b10, 0, 32'h0);
    rd("B top", 32'h107C, 2, 32'h0, 2'b10, 32'hC0FF_0F0F, 2'b00, 0, 32'h0);
    rd("B past", 32'h1080, 0, 32'h0, 2'b10, 32'h0, 2'b10, 0, 32'h0);
    rd("B below", 32'h103C, 0, 32'h0, 2'b10, 32'h0, 2'b10, 0, 32'h0);
`ifdef AXI_READ_RESPONDER_ALIGN_CHECK_EN
    xa6_d = 32'h0;         xa6_r = 2'b10;
`else
    xa6_d = 32'hC001_0F0F; xa6_r = 2'b00;
`endif
    rd("unaligned", 32'h6, 0, xa6_d, xa6_r, 32'h0, 2'b10, 0, 32'h0);
    rd("load+AR", 32'h8, 0, 32'hC002_0F0F, 2'b00, 32'h0, 2'b10, 1, 32'hDEAD_BEEF);
    rd("after load", 32'h8, 0, 32'hDEAD_BEEF, 2'b00, 32'h0, 2'b10, 0, 32'h0);
    rd("B after load", 32'h1048, 0, 32'h0, 2'b10, 32'hDEAD_BEEF, 2'b00, 0, 32'h0);

    // Reset while B waits: no response, then normal service.
    arvalid = 1'b1; araddress = 32'h1044; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) reset = 1'b0;
      if (k == 3) reset = 1'b1;
      @(negedge clk);
      check("rst-in-wait B rvalid", 32'(ifb.rvalid), 32'd0);
      if (k >= 3) begin
        check("rst-in-wait A arready", 32'(ifa.arready), 32'd1);
        check("rst-in-wait B arready", 32'(ifb.arready), 32'd1);
      end
      tick();
    end
    rd("post reset", 32'h3FC, 0, 32'hC0FF_0F0F, 2'b00, 32'h0, 2'b10, 0, 32'h0);
    rd("post reset B", 32'h1044, 1, 32'h0, 2'b10, 32'hC0F1_0F0F, 2'b00, 0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      arvalid    = 1'($urandom_range(0, 1));
      araddress  = pick_addr();
      arprot     = 3'($urandom);
      rready     = ($urandom_range(0, 9) < 6);
      load_en    = reset && ($urandom_range(0, 9) == 0);
      load_index = 8'($urandom);
      load_data  = $urandom;
      tick();
    end
    reset = 1'b1; arvalid = 1'b0; load_en = 1'b0; rready = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words held; power of two, at least 2.
REQ-002 Parameter BASE, default 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
REQ-003 Parameter LATENCY, default 1: cycles from AR handshake to rvalid assertion; range 1..15.
REQ-004 clk  input  1  sole clock, all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 arvalid  input  1  core read-address valid.
REQ-007 arready  output  1  responder accepts an address.
REQ-008 araddress  input  32  byte read address.
REQ-009 arprot  input  3  protection bits; ignored.
REQ-010 rvalid  output  1  read data valid.
REQ-011 rready  input  1  core accepts read data.
REQ-012 rdata  output  32  read data.
REQ-013 rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-014 load_en  input  1  preload strobe, honoured only in IDLE.
REQ-015 load_index  input  clog2(DEPTH)  preload word index.
REQ-016 load_data  input  32  preload word.

Function
REQ-017 The block SHALL be an AXI4-Lite read-only slave feeding the core's AR/R channels, one outstanding transaction at a time.
REQ-018 States SHALL be IDLE, WAIT, RESP.
REQ-019 IDLE: arready=1, rvalid=0; arvalid=1 SHALL complete the handshake that cycle, capture araddress, load the counter with LATENCY-1, and move to WAIT, or to RESP directly when LATENCY=1.
REQ-020 WAIT: arready=0, rvalid=0; the counter SHALL decrement each cycle, with transition to RESP on the cycle it reads 1.
REQ-021 RESP: arready=0, rvalid=1; rdata/rresp SHALL stay stable until rready=1, then the block SHALL return to IDLE next cycle.
REQ-022 Back-to-back: an address SHALL NOT be accepted in the same cycle as an R handshake; the minimum spacing between AR handshakes is LATENCY+1 cycles.
REQ-023 In range means BASE <= addr < BASE+DEPTH*4 (32-bit unsigned compare, no wrap); word index = (addr-BASE)>>2, truncated to clog2(DEPTH) bits.
REQ-024 In range: rdata=mem[index], rresp=2'b00; out of range: rdata=32'h0, rresp=2'b10.
REQ-025 Memory read data SHALL be sampled at the AR handshake; a load_en during WAIT/RESP SHALL be ignored.
REQ-026 load_en in IDLE SHALL write mem[load_index]=load_data; if arvalid is also 1 that cycle, the read SHALL return the old word.
REQ-027 rvalid SHALL NOT depend combinationally on rready; arready SHALL NOT depend combinationally on arvalid.

Reset
REQ-028 With reset=0 at a rising edge: state=IDLE, counter=0, rvalid=0, rdata=32'h0, rresp=2'b00; arready SHALL be 0 while reset=0 and 1 from the first cycle after release.
REQ-029 Reset mid-transaction SHALL abandon it without a response; memory contents SHALL be preserved across reset.

Configuration
REQ-030 Macro AXI_READ_RESPONDER_ALIGN_CHECK_EN defined: an in-range address with araddress[1:0]!=0 SHALL return rresp=2'b10, rdata=32'h0.
REQ-031 Macro undefined: araddress[1:0] SHALL be ignored and the aligned word returned with OKAY.

Verification
REQ-032 LATENCY=1, mem[0]=32'h0000_0013, AR 32'h0 -> rvalid one cycle after handshake, rdata=32'h0000_0013, rresp=00.
REQ-033 LATENCY=3, AR 32'h4, rready=0 for 5 cycles -> rvalid rises 3 cycles after handshake, rdata/rresp stable until rready; arready=0 throughout.
REQ-034 DEPTH=256, BASE=0, AR 32'h400 -> rresp=2'b10, rdata=0; AR 32'h3FC -> OKAY, returns mem[255].
REQ-035 With the macro defined, AR 32'h6 -> SLVERR; without it -> OKAY, returns mem[1].
REQ-036 Same cycle load_en (index 2, 32'hDEAD_BEEF) and AR 32'h8 -> old mem[2] returned; next read of 32'h8 -> 32'hDEAD_BEEF.
REQ-037 reset=0 asserted during WAIT -> rvalid never asserts; after release arready=1 and a fresh read completes normally.
